// File: rtl/cic_pkg.sv
// Shared CIC constants: comb stage count and differential-delay limits,
// plus the clamp used to keep elaborated sizes inside those limits.
package cic_pkg;

    localparam int unsigned N_MIN           = 1;
    localparam int unsigned N_MAX           = 6;
    localparam int unsigned M_MIN           = 1;
    localparam int unsigned M_MAX           = 2;
    localparam int unsigned DELAY_DEPTH_MAX = M_MAX;

    function automatic int unsigned clamp_range(input int unsigned v,
                                                input int unsigned lo,
                                                input int unsigned hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

endpackage

// File: rtl/cic_comb_decim_comb.sv
// Single registered comb (differentiator) stage: y = x - x delayed by M
// accepted samples, modular DW-bit arithmetic, advancing only when en is high.
module comb
    import cic_pkg::*;
#(
    parameter int          DW = 24,
    parameter int unsigned M  = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic signed [DW-1:0] x,
    output logic signed [DW-1:0] y
);

    localparam int unsigned DEPTH = clamp_range(M, M_MIN, DELAY_DEPTH_MAX);

    logic signed [DW-1:0] dly [DEPTH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            y <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) dly[i] <= '0;
        end else if (en) begin
            y      <= x - dly[DEPTH-1];
            dly[0] <= x;
            for (int unsigned i = 1; i < DEPTH; i++) dly[i] <= dly[i-1];
        end
    end

endmodule

// File: rtl/cic_comb_decim.sv
// CIC decimator back end: ce-qualified rate-R decimation, N comb stages,
// then round-half-up / saturating truncation from DW to OW bits.
module cic_comb_decim
    import cic_pkg::*;
#(
    parameter int          DW = 24,
    parameter int          OW = 16,
    parameter int unsigned N  = 3,
    parameter int unsigned M  = 1,
    parameter int          RW = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ce,
    input  logic signed [DW-1:0] din,
    input  logic        [RW-1:0] rate,
    output logic signed [OW-1:0] dout,
    output logic                 dout_valid
);

    localparam int unsigned NS = clamp_range(N, N_MIN, N_MAX);
    localparam int unsigned MD = clamp_range(M, M_MIN, M_MAX);

    logic [RW-1:0]        cnt;
    logic [RW-1:0]        r_lat;
    logic [RW-1:0]        r_cur;
    logic [RW-1:0]        rate_eff;
    logic                 fresh;
    logic                 accept;
    logic signed [DW-1:0] acc_data;
    logic [NS:0]          vld;
    logic signed [DW-1:0] comb_out [NS];
    logic signed [DW-1:0] comb_res;
    logic signed [OW-1:0] rounded;

    assign rate_eff = (rate == '0) ? RW'(1) : rate;
    // The first frame after reset uses the rate present on the release clock.
    assign r_cur    = fresh ? rate_eff : r_lat;
    assign accept   = ce && (cnt == r_cur - RW'(1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt   <= '0;
            r_lat <= RW'(1);
            fresh <= 1'b1;
        end else begin
            fresh <= 1'b0;
            if (fresh || accept) r_lat <= rate_eff;
            if (accept)  cnt <= '0;
            else if (ce) cnt <= cnt + RW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_data <= '0;
            vld      <= '0;
        end else begin
            vld <= {vld[NS-1:0], accept};
            if (accept) acc_data <= din;
        end
    end

    for (genvar k = 0; k < int'(NS); k++) begin : g_stage
        logic signed [DW-1:0] x;
        if (k == 0) begin : g_first
            assign x = acc_data;
        end else begin : g_next
            assign x = comb_out[k-1];
        end
        comb #(.DW(DW), .M(MD)) u_comb (
            .clk   (clk),
            .reset (reset),
            .en    (vld[k]),
            .x     (x),
            .y     (comb_out[k])
        );
    end

    assign comb_res = comb_out[NS-1];

    if (OW == DW) begin : g_full
        assign rounded = comb_res;
    end else begin : g_round
        localparam logic [DW-1:0] HALF = DW'(1) << (DW - OW - 1);
        logic [DW-1:0] sum;
        logic          ovf;
        logic          rnd_unused;
        assign sum        = comb_res + HALF;
        // Only a non-negative input can cross the sign bit when adding HALF.
        assign ovf        = ~comb_res[DW-1] & sum[DW-1];
        assign rounded    = ovf ? {1'b0, {(OW-1){1'b1}}} : sum[DW-1:DW-OW];
        assign rnd_unused = ^sum[DW-OW-1:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dout       <= '0;
            dout_valid <= 1'b0;
        end else begin
            dout_valid <= vld[NS];
            if (vld[NS]) dout <= rounded;
        end
    end

endmodule
